// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration frame loader: default sizing,
// cfg_word field offsets and the write-sequencer state encoding.
package cfg_loader_pkg;

    localparam int DEF_ADDR_W          = 7;
    localparam int DEF_EXPECTED_WRITES = 56;
    localparam int DEF_CNT_W           = 8;

    // cfg_word layout: {parity, address[ADDR_W-1:0], data}
    localparam int DATA_BIT = 0;
    localparam int ADDR_LSB = 1;

    // The parity bit sits directly above the address field.
    function automatic int parity_bit(input int addr_w);
        return addr_w + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/cfg_parity_chk.sv
// Combinational even-parity checker for one configuration word.
// parity_ok is high when payload plus parity bit hold an even number of ones.
module cfg_parity_chk #(
    parameter int PAYLOAD_W = 8
) (
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic                 parity,
    output logic                 parity_ok
);

    assign parity_ok = ~((^payload) ^ parity);

endmodule

// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: accepts {parity, address, data} words on a
// valid/ready stream and turns each into a SETUP/STROBE/HOLD write cycle on
// the tile's enable/address/data_in bus, counting writes until a frame is
// complete.
// Optional build macro CFG_FRAME_LOADER_PARITY_EN: when defined, words failing
// even parity are consumed without a write and raise a sticky err.
module cfg_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int EXPECTED_WRITES = DEF_EXPECTED_WRITES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              cfg_start,
    input  logic [ADDR_W+1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic              data_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err
);

    localparam int               PARITY_BIT = parity_bit(ADDR_W);
    localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(EXPECTED_WRITES);

    state_e            state_q,     state_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              enable_q,    enable_d;
    logic [ADDR_W-1:0] address_q,   address_d;
    logic              data_in_q,   data_in_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [CNT_W-1:0]  wr_count_q,  wr_count_d;
    logic              err_q,       err_d;
    logic              word_ok;

`ifdef CFG_FRAME_LOADER_PARITY_EN
    // Even-parity screen over the whole incoming word.
    cfg_parity_chk #(
        .PAYLOAD_W (ADDR_W + 1)
    ) u_parity_chk (
        .payload   (cfg_word[ADDR_W:0]),
        .parity    (cfg_word[PARITY_BIT]),
        .parity_ok (word_ok)
    );
`else
    logic unused_parity;
    assign unused_parity = cfg_word[PARITY_BIT];
    assign word_ok       = 1'b1;
`endif

    // Next-state and next-output computation for the write sequencer.
    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        address_d  = address_q;
        data_in_d  = data_in_q;
        busy_d     = busy_q;
        done_d     = done_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d    = ST_ARMED;
                    wr_count_d = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (cfg_valid && cfg_ready_q) begin
                    if (word_ok) begin
                        address_d = cfg_word[ADDR_LSB +: ADDR_W];
                        data_in_d = cfg_word[DATA_BIT];
                        state_d   = ST_SETUP;
                    end else begin
                        // Bad word is swallowed; stay armed for the next one.
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
                if (wr_count_q != FRAME_CNT) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (wr_count_q == FRAME_CNT) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe and ready are decoded from the next state so they come out
        // of flops and line up exactly with the state they belong to.
        enable_d    = (state_d == ST_STROBE);
        cfg_ready_d = (state_d == ST_ARMED);
    end

    // State and registered outputs; reset drops enable at once, discarding
    // any write in flight.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b0;
            enable_q    <= 1'b0;
            address_q   <= '0;
            data_in_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_count_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            enable_q    <= enable_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign enable    = enable_q;
    assign address   = address_q;
    assign data_in   = data_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_count  = wr_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: directed sequence with random
// configuration words, compared against a transaction-level reference model.
module tb_cfg_frame_loader;

    localparam int ADDR_W = 7;
    localparam int EXP_WR = 56;
    localparam int CNT_W  = 8;
    localparam int WORD_W = ADDR_W + 2;

    logic              prog_clk  = 1'b0;
    logic              pReset_n  = 1'b0;
    logic              cfg_start = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [WORD_W-1:0] cfg_word  = '0;
    logic              cfg_ready;
    logic              enable;
    logic [ADDR_W-1:0] address;
    logic              data_in;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  wr_count;
    logic              err;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_enable  = 0;

    // Reference model: what the tile should have seen so far.
    int                m_count = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic              m_data  = 1'b0;
    logic              m_busy  = 1'b0;
    logic              m_done  = 1'b0;
    logic              m_err   = 1'b0;

    cfg_frame_loader #(
        .ADDR_W          (ADDR_W),
        .EXPECTED_WRITES (EXP_WR),
        .CNT_W           (CNT_W)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .cfg_start (cfg_start),
        .cfg_word  (cfg_word),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .enable    (enable),
        .address   (address),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .err       (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Independent tally of strobe cycles seen on the bus.
    always @(negedge prog_clk) begin
        if (enable === 1'b1) n_enable++;
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_en, input logic exp_rdy);
        check({tag, ".enable"},    32'(enable),    32'(exp_en));
        check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(exp_rdy));
        check({tag, ".address"},   32'(address),   32'(m_addr));
        check({tag, ".data_in"},   32'(data_in),   32'(m_data));
        check({tag, ".wr_count"},  32'(wr_count),  32'(m_count));
        check({tag, ".busy"},      32'(busy),      32'(m_busy));
        check({tag, ".done"},      32'(done),      32'(m_done));
        check({tag, ".err"},       32'(err),       32'(m_err));
    endtask

    // Builds {parity, addr, data} with even parity when good=1, odd otherwise.
    function automatic logic [WORD_W-1:0] make_word(input logic [ADDR_W-1:0] a,
                                                    input logic d, input logic good);
        logic p;
        p = (^{a, d}) ^ ~good;
        return {p, a, d};
    endfunction

    function automatic logic word_good(input logic [WORD_W-1:0] w);
`ifdef CFG_FRAME_LOADER_PARITY_EN
        return (^w) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Offers one word with cfg_valid held high and checks every cycle of the
    // resulting write (or of the rejection for a bad-parity word).
    task automatic send_word(input logic [WORD_W-1:0] w);
        int waited = 0;
        cfg_word  = w;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_wait", 32'(cfg_ready), 32'd1);
        if (cfg_ready !== 1'b1) return;
        tick();
        if (word_good(w)) begin
            m_addr = w[ADDR_W:1];
            m_data = w[0];
            check_state("setup", 1'b0, 1'b0);
            tick();
            check_state("strobe", 1'b1, 1'b0);
            tick();
            if (m_count < EXP_WR) m_count++;
            check_state("hold", 1'b0, 1'b0);
            tick();
            if (m_count == EXP_WR) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
            check_state("next", 1'b0, m_count != EXP_WR);
        end else begin
            cfg_valid = 1'b0;
            m_err     = 1'b1;
            check_state("bad_word", 1'b0, 1'b1);
            tick();
            check_state("bad_word2", 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        int                en_base;
        bit                did_start = 1'b0;
        bit                did_bad   = 1'b0;

        // Reset and idle: word 0x55 offered in IDLE must not be consumed.
        cfg_word  = 9'h055;
        cfg_valid = 1'b1;
        repeat (3) tick();
        check_state("in_reset", 1'b0, 1'b0);
        pReset_n = 1'b1;
        repeat (4) tick();
        check_state("idle_valid", 1'b0, 1'b0);
        cfg_valid = 1'b0;

        // Arm and issue the directed single write to 0x2A with data 1.
        pulse_start();
        m_busy = 1'b1;
        check_state("armed", 1'b0, 1'b1);
        en_base = n_enable;
        send_word(make_word(7'h2A, 1'b1, 1'b1));

        // Rest of the frame with random words; start pulse at 10, bad word at 20.
        while (m_count < EXP_WR) begin
            if (m_count == 10 && !did_start) begin
                did_start = 1'b1;
                cfg_valid = 1'b0;
                pulse_start();
                check_state("start_busy", 1'b0, 1'b1);
            end else if (m_count == 20 && !did_bad) begin
                did_bad = 1'b1;
                send_word(make_word(7'($urandom), 1'($urandom), 1'b0));
            end else begin
                send_word(make_word(7'($urandom), 1'($urandom), $urandom_range(0, 7) != 0));
            end
        end
        check("frame_enable_pulses", 32'(n_enable - en_base), 32'(EXP_WR));

        // Extra words after done are not consumed.
        cfg_word  = make_word(7'h7F, ~m_data, 1'b1);
        cfg_valid = 1'b1;
        repeat (5) tick();
        check_state("after_done", 1'b0, 1'b0);
        check("after_done_pulses", 32'(n_enable - en_base), 32'(EXP_WR));
        cfg_valid = 1'b0;

        // New start from IDLE clears counter, done and err.
        pulse_start();
        m_count = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_busy  = 1'b1;
        check_state("restart", 1'b0, 1'b1);

        // Reset during STROBE: enable drops at once, write is not counted.
        w         = make_word(7'h15, 1'b1, 1'b1);
        cfg_word  = w;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        check("pre_reset_strobe", 32'(enable), 32'd1);
        pReset_n = 1'b0;
        #1;
        m_addr = '0;
        m_data = 1'b0;
        m_busy = 1'b0;
        check_state("mid_reset", 1'b0, 1'b0);
        tick();
        pReset_n = 1'b1;
        repeat (3) tick();
        check_state("post_reset_idle", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
